// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port.
// Registers the winning write, drops x0 writes and flags forwarding hits.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [2:0]                rf_wsrc,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  input  logic [ADDR_W-1:0]         fwd_raddr1,
  input  logic [ADDR_W-1:0]         fwd_raddr2
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]     rrPtr;
  logic [PW-1:0]     gntIdx;
  logic [PW-1:0]     rrNext;
  logic              gntAny;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  // Search starts at rrPtr and wraps; the first valid source wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx    = 0;
    cand   = '0;
    gntAny = 1'b0;
    gntIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!gntAny && req_valid[cand]) begin
        gntAny = 1'b1;
        gntIdx = cand;
      end
    end
    if (wb_hold || !rst_n) gntAny = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gntAny) req_ready = NUM_REQ'(1) << gntIdx;
  end

  assign rrNext = (gntIdx == PW'(NUM_REQ - 1)) ? '0
                : gntIdx + PW'(1);
  assign selAddr = req_addr[int'(gntIdx)*ADDR_W +: ADDR_W];
  assign selData = req_data[int'(gntIdx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_wsrc  <= '0;
    end else if (gntAny) begin
      rrPtr    <= rrNext;
      rf_we    <= (selAddr != '0);
      rf_waddr <= selAddr;
      rf_wdata <= selData;
      rf_wsrc  <= 3'(gntIdx);
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign fwd_hit1 = rf_we && (rf_waddr == fwd_raddr1)
                 && (fwd_raddr1 != '0);
  assign fwd_hit2 = rf_we && (rf_waddr == fwd_raddr2)
                 && (fwd_raddr2 != '0);

  readyOneHot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ready)
  );

endmodule
